// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb
// Purpose  : Architectural integer register file at the MEM/WB write-back
//            boundary. Commits wb_des_* into NREG GPRs (r0 hardwired to 0),
//            serves two combinational read ports to ID and counts retired
//            write-backs.
// Options  : REGFILE_WB_BYPASS_EN - when defined, a read that hits the
//            register being written in the same cycle returns wb_des_data.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic [ADDR_W-1:0] wb_des_addr,
  input  logic              wb_des_exist,
  input  logic [DATA_W-1:0] wb_des_data,
  input  logic              rd1_en,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic              rd2_en,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  // Register storage; entry 0 is only ever loaded by reset, so it stays 0.
  logic [DATA_W-1:0] regs_q [NREG];
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              wr_en_w;

  // A write commits only for a valid, non-r0, in-range destination.
  assign wr_en_w = wb_des_exist && (wb_des_addr != '0) && (int'(wb_des_addr) < NREG);

  // Retire counter counts every valid write-back (r0 included) and wraps.
  assign cnt_d = cnt_q + CNT_W'(1);

  // Register array update; reset clears every entry immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_w) begin
      regs_q[wb_des_addr] <= wb_des_data;
    end
  end

  // Retired write-back counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (wb_des_exist) begin
      cnt_q <= cnt_d;
    end
  end

  assign retire_cnt = cnt_q;

  // Read port 1: reset, disable and r0 all force zero, then optional bypass.
  always_comb begin
    rd1_data = '0;
    if (rst && rd1_en && (rd1_addr != '0) && (int'(rd1_addr) < NREG)) begin
`ifdef REGFILE_WB_BYPASS_EN
      if (wb_des_exist && (wb_des_addr == rd1_addr)) begin
        rd1_data = wb_des_data;
      end else begin
        rd1_data = regs_q[rd1_addr];
      end
`else
      rd1_data = regs_q[rd1_addr];
`endif
    end
  end

  // Read port 2: identical structure, fully independent of port 1.
  always_comb begin
    rd2_data = '0;
    if (rst && rd2_en && (rd2_addr != '0) && (int'(rd2_addr) < NREG)) begin
`ifdef REGFILE_WB_BYPASS_EN
      if (wb_des_exist && (wb_des_addr == rd2_addr)) begin
        rd2_data = wb_des_data;
      end else begin
        rd2_data = regs_q[rd2_addr];
      end
`else
      rd2_data = regs_q[rd2_addr];
`endif
    end
  end

endmodule
`default_nettype wire
